hall_call_dispatcher: RTL and testbench

Upstream stage of the multi-lift controller. Latches hall up/down button presses into pending calls and drives the hall status lamps. Picks one unassigned pending call at a time and assigns it to the nearest lift. Emits the assignment over a valid/ready handshake to the per-lift request logic. Clears each call when a lift serves it.

---
 rtl/lift_pkg.sv | 26 ++
 rtl/hall_call_dispatcher_rr_slot_picker.sv | 32 +++
 rtl/hall_call_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and slot/floor helpers for the hall call dispatcher.
package lift_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, OFFER} disp_state_e;

  // Widest floor_sense slice the one-hot encoder accepts.
  localparam int MAX_FLOORS = 64;

  function automatic int floor_of_slot(input int slot, input int n_floors);
    return (slot >= n_floors) ? slot - n_floors : slot;
  endfunction

  function automatic logic dir_of_slot(input int slot, input int n_floors);
    return (slot < n_floors);
  endfunction

  function automatic int onehot_to_index(input logic [MAX_FLOORS-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hall_call_dispatcher_rr_slot_picker.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
module rr_slot_picker #(
  parameter int N_SLOTS = 24,
  parameter int SW      = 5
) (
  input  logic [N_SLOTS-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic               found,
  output logic [SW-1:0]      slot
);

  localparam int PW = SW + 1;

  logic [N_SLOTS-1:0] w_rot;
  logic [PW-1:0]      w_off;
  logic [PW-1:0]      w_sum;

  // Bit i of w_rot is request (ptr + i) mod N_SLOTS.
  assign w_rot = N_SLOTS'({req, req} >> ptr);

  always_comb begin
    w_off = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end
  end

  assign w_sum = {1'b0, ptr} + w_off;
  assign found = |req;
  assign slot  = (w_sum >= PW'(N_SLOTS)) ? SW'(w_sum - PW'(N_SLOTS)) : w_sum[SW-1:0];

endmodule

// File: rtl/hall_call_dispatcher.sv
// Latches hall calls, assigns one unassigned call at a time to the nearest lift,
// and offers it downstream over valid/ready.
//
// state  | meaning
// IDLE   | waiting for a pending, unassigned call
// SEARCH | scanning one lift per cycle for the smallest floor distance
// OFFER  | assignment held on the outputs until ready or the call is served
module hall_call_dispatcher
  import lift_pkg::*;
#(
  parameter int N_FLOORS = 12,
  parameter int N_LIFTS  = 10,
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1,
  localparam int LW = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1,
  localparam int SW = $clog2(2 * N_FLOORS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         up_rqst,
  input  logic [N_FLOORS-1:0]         dn_rqst,
  input  logic [N_LIFTS*N_FLOORS-1:0] floor_sense,
  input  logic [N_LIFTS-1:0]          direction,
  input  logic [N_LIFTS-1:0]          door_open,
  output logic [N_FLOORS-1:0]         up_rqst_status,
  output logic [N_FLOORS-1:0]         dn_rqst_status,
  output logic                        assign_valid,
  input  logic                        assign_ready,
  output logic [LW-1:0]               assign_lift,
  output logic [FW-1:0]               assign_floor,
  output logic                        assign_dir
);

  localparam int NS = 2 * N_FLOORS;
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] r_up_pend;
  logic [N_FLOORS-1:0] r_dn_pend;
  logic [NS-1:0]       r_assigned;
  logic [FW-1:0]       r_last_floor [N_LIFTS];

  disp_state_e         r_state;
  logic [SW-1:0]       r_cur_slot;
  logic [SW-1:0]       r_rr_ptr;
  logic [FW-1:0]       r_cur_floor;
  logic                r_cur_dir;
  logic [LW-1:0]       r_lift_idx;
  logic [LW-1:0]       r_best_lift;
  logic [FW-1:0]       r_best_cost;

  logic                r_assign_valid;
  logic [LW-1:0]       r_assign_lift;
  logic [FW-1:0]       r_assign_floor;
  logic                r_assign_dir;

  logic [N_FLOORS-1:0] w_served_up;
  logic [N_FLOORS-1:0] w_served_dn;
  logic [NS-1:0]       w_served;
  logic [NS-1:0]       w_req;
  logic [NS-1:0]       w_accept_mask;
  logic                w_found;
  logic [SW-1:0]       w_pick;
  logic [FW-1:0]       w_lf;
  logic [FW-1:0]       w_cost;
  logic                w_better;
  logic                w_cur_served;
  logic                w_last_lift;
  logic                w_accept;

  always_comb begin
    w_served_up = '0;
    w_served_dn = '0;
    for (int l = 0; l < N_LIFTS; l++) begin
      for (int f = 0; f < N_FLOORS; f++) begin
        if (floor_sense[l*N_FLOORS + f] && door_open[l]) begin
          if (direction[l]) w_served_up[f] = 1'b1;
          else              w_served_dn[f] = 1'b1;
        end
      end
    end
  end

  assign w_served = {w_served_dn, w_served_up};
  // A call being served this cycle is not worth starting a search for.
  assign w_req    = {r_dn_pend, r_up_pend} & ~r_assigned & ~w_served;

  rr_slot_picker #(
    .N_SLOTS (NS),
    .SW      (SW)
  ) u_picker (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .slot  (w_pick)
  );

  assign w_lf          = r_last_floor[r_lift_idx];
  assign w_cost        = (w_lf >= r_cur_floor) ? (w_lf - r_cur_floor) : (r_cur_floor - w_lf);
  assign w_better      = (w_cost < r_best_cost);
  assign w_cur_served  = w_served[r_cur_slot];
  assign w_last_lift   = (r_lift_idx == LW'(N_LIFTS - 1));
  assign w_accept      = (r_state == OFFER) && assign_ready && !w_cur_served;
  assign w_accept_mask = w_accept ? (NS'(1) << r_cur_slot) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_up_pend  <= '0;
      r_dn_pend  <= '0;
      r_assigned <= '0;
      for (int l = 0; l < N_LIFTS; l++) r_last_floor[l] <= '0;
    end else begin
      // Service clears win over a simultaneous press.
      r_up_pend  <= (r_up_pend | (up_rqst & UP_MASK)) & ~w_served_up;
      r_dn_pend  <= (r_dn_pend | (dn_rqst & DN_MASK)) & ~w_served_dn;
      r_assigned <= (r_assigned | w_accept_mask) & ~w_served;
      for (int l = 0; l < N_LIFTS; l++) begin
        if (|floor_sense[l*N_FLOORS +: N_FLOORS]) begin
          r_last_floor[l] <= FW'(onehot_to_index(MAX_FLOORS'(floor_sense[l*N_FLOORS +: N_FLOORS])));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cur_slot     <= '0;
      r_rr_ptr       <= '0;
      r_cur_floor    <= '0;
      r_cur_dir      <= 1'b0;
      r_lift_idx     <= '0;
      r_best_lift    <= '0;
      r_best_cost    <= '1;
      r_assign_valid <= 1'b0;
      r_assign_lift  <= '0;
      r_assign_floor <= '0;
      r_assign_dir   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_cur_slot  <= w_pick;
            r_cur_floor <= FW'(floor_of_slot(int'(w_pick), N_FLOORS));
            r_cur_dir   <= dir_of_slot(int'(w_pick), N_FLOORS);
            r_lift_idx  <= '0;
            r_best_lift <= '0;
            r_best_cost <= '1;
            r_state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (w_cur_served) begin
            r_state <= IDLE;
          end else begin
            if (w_better) begin
              r_best_cost <= w_cost;
              r_best_lift <= r_lift_idx;
            end
            if (w_last_lift) begin
              r_state        <= OFFER;
              r_assign_valid <= 1'b1;
              r_assign_lift  <= w_better ? r_lift_idx : r_best_lift;
              r_assign_floor <= r_cur_floor;
              r_assign_dir   <= r_cur_dir;
            end else begin
              r_lift_idx <= r_lift_idx + 1'b1;
            end
          end
        end
        OFFER: begin
          // Withdraw takes priority: a served call must not be marked assigned.
          if (w_cur_served || assign_ready) begin
            r_state        <= IDLE;
            r_assign_valid <= 1'b0;
            r_assign_lift  <= '0;
            r_assign_floor <= '0;
            r_assign_dir   <= 1'b0;
            if (!w_cur_served) begin
              r_rr_ptr <= (r_cur_slot == SW'(NS - 1)) ? '0 : r_cur_slot + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up_rqst_status = r_up_pend;
  assign dn_rqst_status = r_dn_pend;
  assign assign_valid   = r_assign_valid;
  assign assign_lift    = r_assign_lift;
  assign assign_floor   = r_assign_floor;
  assign assign_dir     = r_assign_dir;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher with 4 floors and 2 lifts; accepted offers are
// matched against a queue of expected assignments.
module tb_hall_call_dispatcher;

  localparam int NF = 4;
  localparam int NL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] up_rqst, dn_rqst;
  logic [NL*NF-1:0] floor_sense;
  logic [NL-1:0] direction, door_open;
  logic [NF-1:0] up_rqst_status, dn_rqst_status;
  logic          assign_valid, assign_ready;
  logic [0:0]    assign_lift;
  logic [1:0]    assign_floor;
  logic          assign_dir;

  typedef struct {int lift; int floor; int dir;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;
  int seen;

  hall_call_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL)) dut (
    .clk            (clk),
    .reset          (reset),
    .up_rqst        (up_rqst),
    .dn_rqst        (dn_rqst),
    .floor_sense    (floor_sense),
    .direction      (direction),
    .door_open      (door_open),
    .up_rqst_status (up_rqst_status),
    .dn_rqst_status (dn_rqst_status),
    .assign_valid   (assign_valid),
    .assign_ready   (assign_ready),
    .assign_lift    (assign_lift),
    .assign_floor   (assign_floor),
    .assign_dir     (assign_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic push(input int l, input int f, input int d);
    exp_t e;
    e.lift = l; e.floor = f; e.dir = d;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    up_rqst = '0; dn_rqst = '0; floor_sense = '0;
    direction = '0; door_open = '0; assign_ready = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({up_rqst_status, dn_rqst_status, assign_valid, assign_lift, assign_floor, assign_dir});
  endfunction

  task automatic watch_no_valid(input string tag, input int n);
    int s;
    s = 0;
    repeat (n) begin
      tick(1);
      if (assign_valid) s = 1;
    end
    chk(tag, 32'(s), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset && assign_valid && assign_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_lift",  32'(assign_lift),  32'(mon_e.lift));
        chk("sb_floor", 32'(assign_floor), 32'(mon_e.floor));
        chk("sb_dir",   32'(assign_dir),   32'(mon_e.dir));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: outputs held at zero under reset while inputs toggle
    reset = 1'b0;
    assign_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_rqst = 4'($urandom); dn_rqst = 4'($urandom);
      floor_sense = 8'($urandom); direction = 2'($urandom); door_open = 2'($urandom);
      assign_ready = 1'($urandom);
      tick(1);
      chk("rst_outs", outs(), 32'd0);
    end
    do_reset();
    up_rqst = 4'b0100;
    push(0, 2, 1);
    tick(1);
    up_rqst = '0;
    chk("t1_lamp_up", 32'(up_rqst_status), 32'h4);
    chk("t1_lamp_dn", 32'(dn_rqst_status), 32'h0);
    tick(2);
    chk("t1_valid_early", 32'(assign_valid), 32'd0);
    tick(1);
    chk("t1_valid_t4", 32'(assign_valid), 32'd1);
    assign_ready = 1'b1;
    tick(1);
    assign_ready = 1'b0;
    chk("t1_valid_drop", 32'(assign_valid), 32'd0);

    // 2: nearest lift, stable hold under backpressure, no re-offer
    do_reset();
    floor_sense = 8'b1000_0001;
    tick(1);
    dn_rqst = 4'b1000;
    push(1, 3, 0);
    tick(1);
    dn_rqst = '0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold", 32'({assign_valid, assign_lift, assign_floor, assign_dir}), 32'b11110);
      tick(1);
    end
    assign_ready = 1'b1;
    tick(1);
    assign_ready = 1'b0;
    chk("t2_valid_drop", 32'(assign_valid), 32'd0);
    watch_no_valid("t2_no_reoffer", 8);
    chk("t2_lamp_dn", 32'(dn_rqst_status), 32'h8);

    // 3: ignored buttons, then tie goes to lift 0
    do_reset();
    floor_sense = 8'b0010_0010;
    up_rqst = 4'b1000;
    dn_rqst = 4'b0001;
    tick(1);
    up_rqst = '0; dn_rqst = '0;
    chk("t3_ignored_lamps", 32'({up_rqst_status, dn_rqst_status}), 32'd0);
    watch_no_valid("t3_ignored_novalid", 6);
    up_rqst = 4'b0100;
    push(0, 2, 1);
    tick(1);
    up_rqst = '0;
    tick(3);
    chk("t3_valid", 32'(assign_valid), 32'd1);
    assign_ready = 1'b1;
    tick(1);
    assign_ready = 1'b0;

    // 4: service clear depends on travel direction; clear beats press
    do_reset();
    up_rqst = 4'b0010;
    tick(1);
    up_rqst = '0;
    floor_sense = 8'b0000_0010;
    door_open = 2'b01;
    direction = 2'b00;
    tick(2);
    chk("t4_wrong_dir_lit", 32'(up_rqst_status), 32'h2);
    direction = 2'b01;
    tick(1);
    chk("t4_served_clear", 32'(up_rqst_status), 32'h0);
    tick(1);
    chk("t4_valid_idle", 32'(assign_valid), 32'd0);
    up_rqst = 4'b0010;
    tick(1);
    chk("t4_clear_wins", 32'(up_rqst_status), 32'h0);
    door_open = 2'b00;
    tick(1);
    chk("t4_relatch", 32'(up_rqst_status), 32'h2);
    up_rqst = '0;

    // 5: withdraw when the offered call is served
    do_reset();
    up_rqst = 4'b0100;
    tick(1);
    up_rqst = '0;
    tick(3);
    chk("t5_offer", 32'({assign_valid, assign_lift, assign_floor, assign_dir}), 32'b10101);
    floor_sense = 8'b0100_0000;
    direction = 2'b10;
    door_open = 2'b10;
    tick(1);
    chk("t5_withdraw_outs", outs(), 32'd0);
    door_open = 2'b00;
    watch_no_valid("t5_no_reoffer", 6);

    // 6: round-robin order 0,1,6 then async reset during an offer
    do_reset();
    up_rqst = 4'b0011;
    dn_rqst = 4'b0100;
    push(0, 0, 1);
    push(0, 1, 1);
    push(0, 2, 0);
    tick(1);
    up_rqst = '0; dn_rqst = '0;
    assign_ready = 1'b1;
    seen = 0;
    while (sb.size() != 0 && seen < 60) begin
      tick(1);
      seen++;
    end
    chk("t6_drain", 32'(sb.size()), 32'd0);
    tick(1);
    assign_ready = 1'b0;
    dn_rqst = 4'b0010;
    tick(1);
    dn_rqst = '0;
    tick(3);
    chk("t6_offer", 32'({assign_valid, assign_floor, assign_dir}), 32'b1010);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_rst", outs(), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
